ifu_fetch_ctrl: RTL and testbench

- Instruction fetch unit at the opposite end of the execute stage's next-PC path: consumes the nextpc that execute produces and fetches the instruction at that address.
- Holds the architectural PC and issues single-beat AXI-lite-style read requests (AR/R channels) to instruction memory.
- Presents the fetched 32-bit instruction to decode with a valid/ready handshake.
- Single outstanding fetch; strictly one instruction in flight (multi-cycle, non-pipelined core).

---
 rtl/ifu_fetch_ctrl.sv | 115 +++++++++++
 tb/tb_ifu_fetch_ctrl.sv | 324 ++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/ifu_fetch_ctrl.sv
// Instruction fetch controller: holds the PC, issues one AXI-lite read per instruction and
// hands the selected 32-bit word to decode over a valid/ready handshake.
module ifu_fetch_ctrl #(
  parameter logic [63:0] RESET_PC = 64'h0000_0000_8000_0000
) (
  input  logic        clk,
  input  logic        rst,
  output logic [63:0] ifu_araddr,
  output logic        ifu_arvalid,
  input  logic        ifu_arready,
  input  logic [63:0] ifu_rdata,
  input  logic [1:0]  ifu_rresp,
  input  logic        ifu_rvalid,
  output logic        ifu_rready,
  output logic [31:0] inst,
  output logic [63:0] inst_pc,
  output logic        inst_valid,
  input  logic        inst_ready,
  output logic        inst_err,
  input  logic [63:0] nextpc,
  input  logic        nextpc_valid,
  output logic [63:0] pc
);

  localparam logic [1:0] StReq  = 2'd0;
  localparam logic [1:0] StWait = 2'd1;
  localparam logic [1:0] StHold = 2'd2;
  localparam logic [1:0] StExec = 2'd3;

  logic [1:0]  state_q, state_d;
  logic [63:0] pc_q, pc_d;
  logic [31:0] inst_q, inst_d;
  logic [63:0] inst_pc_q, inst_pc_d;
  logic        inst_err_q, inst_err_d;
  // Low while reset is held so the bus handshakes stay quiet; registered to keep rst off the
  // output cone.
  logic        bus_en_q, bus_en_d;
  logic        redirect;

  always_comb begin
    ifu_araddr  = pc_q;
    ifu_arvalid = bus_en_q && (state_q == StReq);
    ifu_rready  = bus_en_q && (state_q == StWait);
    inst_valid  = (state_q == StHold);
    inst        = inst_q;
    inst_pc     = inst_pc_q;
    inst_err    = inst_err_q;
    pc          = pc_q;
  end

  always_comb begin
    state_d    = state_q;
    pc_d       = pc_q;
    inst_d     = inst_q;
    inst_pc_d  = inst_pc_q;
    inst_err_d = inst_err_q;
    bus_en_d   = 1'b1;
    redirect   = 1'b0;

    case (state_q)
      StReq: begin
        if (ifu_arvalid && ifu_arready) state_d = StWait;
      end
      StWait: begin
        if (ifu_rready && ifu_rvalid) begin
          inst_d     = pc_q[2] ? ifu_rdata[63:32] : ifu_rdata[31:0];
          inst_pc_d  = pc_q;
          inst_err_d = (ifu_rresp != 2'b00);
          state_d    = StHold;
        end
      end
      StHold: begin
        if (inst_ready) begin
          state_d  = StExec;
          redirect = nextpc_valid;
        end
      end
      default: begin
        redirect = nextpc_valid;
      end
    endcase

    // Shared by EXEC and by a HOLD handshake that coincides with the redirect strobe.
    if (redirect) begin
      pc_d = nextpc;
      if (nextpc[1:0] == 2'b00) begin
        state_d = StReq;
      end else begin
        inst_d     = 32'd0;
        inst_pc_d  = nextpc;
        inst_err_d = 1'b1;
        state_d    = StHold;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q    <= StReq;
      pc_q       <= RESET_PC;
      inst_q     <= 32'd0;
      inst_pc_q  <= 64'd0;
      inst_err_q <= 1'b0;
      bus_en_q   <= 1'b0;
    end else begin
      state_q    <= state_d;
      pc_q       <= pc_d;
      inst_q     <= inst_d;
      inst_pc_q  <= inst_pc_d;
      inst_err_q <= inst_err_d;
      bus_en_q   <= bus_en_d;
    end
  end

endmodule

// File: tb/tb_ifu_fetch_ctrl.sv
// Self-checking bench for ifu_fetch_ctrl: a scoreboard of expected instructions is filled as
// read responses are driven and drained when decode accepts an instruction.
module tb_ifu_fetch_ctrl;

  localparam logic [63:0] ResetPc = 64'h0000_0000_8000_0000;

  logic        clk;
  logic        rst;
  logic [63:0] ifu_araddr;
  logic        ifu_arvalid;
  logic        ifu_arready;
  logic [63:0] ifu_rdata;
  logic [1:0]  ifu_rresp;
  logic        ifu_rvalid;
  logic        ifu_rready;
  logic [31:0] inst;
  logic [63:0] inst_pc;
  logic        inst_valid;
  logic        inst_ready;
  logic        inst_err;
  logic [63:0] nextpc;
  logic        nextpc_valid;
  logic [63:0] pc;

  typedef struct packed {
    logic [31:0] inst;
    logic [63:0] pc;
    logic        err;
  } exp_t;

  exp_t        sb[$];
  int          vec;
  int          miscmp;
  logic [63:0] exp_pc;

  ifu_fetch_ctrl #(.RESET_PC(ResetPc)) dut (
    .clk          (clk),
    .rst          (rst),
    .ifu_araddr   (ifu_araddr),
    .ifu_arvalid  (ifu_arvalid),
    .ifu_arready  (ifu_arready),
    .ifu_rdata    (ifu_rdata),
    .ifu_rresp    (ifu_rresp),
    .ifu_rvalid   (ifu_rvalid),
    .ifu_rready   (ifu_rready),
    .inst         (inst),
    .inst_pc      (inst_pc),
    .inst_valid   (inst_valid),
    .inst_ready   (inst_ready),
    .inst_err     (inst_err),
    .nextpc       (nextpc),
    .nextpc_valid (nextpc_valid),
    .pc           (pc)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout, want $finish");
    $fatal(1);
  end

  // Scoreboard drain: every decode handshake must match the oldest expected instruction.
  always @(negedge clk) begin
    if (rst && inst_valid && inst_ready) begin
      exp_t e;
      vec++;
      if (sb.size() == 0) begin
        miscmp++;
        $display("FAIL sb_empty: got inst=%h pc=%h err=%b, want no instruction", inst, inst_pc,
                 inst_err);
      end else begin
        e = sb.pop_front();
        if ({inst, inst_pc, inst_err} !== {e.inst, e.pc, e.err}) begin
          miscmp++;
          $display("FAIL sb_inst: got inst=%h pc=%h err=%b, want inst=%h pc=%h err=%b",
                   inst, inst_pc, inst_err, e.inst, e.pc, e.err);
        end
      end
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Expects the DUT in REQ; completes AR with no stall and returns data one cycle later.
  task automatic do_fetch(input logic [63:0] rdata, input logic [1:0] resp);
    exp_t e;
    vec++;
    if ({ifu_arvalid, ifu_araddr} !== {1'b1, exp_pc}) begin
      miscmp++;
      $display("FAIL fetch_ar: got arvalid=%b araddr=%h, want arvalid=1 araddr=%h",
               ifu_arvalid, ifu_araddr, exp_pc);
    end
    ifu_arready = 1'b1;
    step();
    ifu_arready = 1'b0;
    vec++;
    if ({ifu_arvalid, ifu_rready, inst_valid} !== 3'b010) begin
      miscmp++;
      $display("FAIL fetch_wait: got arvalid=%b rready=%b inst_valid=%b, want 0 1 0",
               ifu_arvalid, ifu_rready, inst_valid);
    end
    ifu_rvalid = 1'b1;
    ifu_rdata  = rdata;
    ifu_rresp  = resp;
    e.inst = exp_pc[2] ? rdata[63:32] : rdata[31:0];
    e.pc   = exp_pc;
    e.err  = (resp != 2'b00);
    sb.push_back(e);
    step();
    ifu_rvalid = 1'b0;
    ifu_rdata  = 64'hdead_beef_dead_beef;
    ifu_rresp  = 2'b00;
    vec++;
    if ({inst_valid, inst_err, pc} !== {1'b1, e.err, exp_pc}) begin
      miscmp++;
      $display("FAIL fetch_hold: got inst_valid=%b err=%b pc=%h, want 1 %b %h",
               inst_valid, inst_err, pc, e.err, exp_pc);
    end
  endtask

  // Expects the DUT in HOLD; handshake with a simultaneous redirect.
  task automatic accept_redirect(input logic [63:0] target);
    exp_t e;
    inst_ready   = 1'b1;
    nextpc_valid = 1'b1;
    nextpc       = target;
    if (target[1:0] != 2'b00) begin
      e.inst = 32'd0;
      e.pc   = target;
      e.err  = 1'b1;
      sb.push_back(e);
    end
    step();
    inst_ready   = 1'b0;
    nextpc_valid = 1'b0;
    exp_pc       = target;
    vec++;
    if (target[1:0] == 2'b00) begin
      if ({ifu_arvalid, ifu_araddr, inst_valid, pc} !== {1'b1, target, 1'b0, target}) begin
        miscmp++;
        $display("FAIL redirect: got arvalid=%b araddr=%h inst_valid=%b pc=%h, want 1 %h 0 %h",
                 ifu_arvalid, ifu_araddr, inst_valid, pc, target, target);
      end
    end else begin
      if ({ifu_arvalid, inst_valid, pc} !== {1'b0, 1'b1, target}) begin
        miscmp++;
        $display("FAIL redirect_mis: got arvalid=%b inst_valid=%b pc=%h, want 0 1 %h",
                 ifu_arvalid, inst_valid, pc, target);
      end
    end
  endtask

  task automatic test_reset();
    rst = 1'b0;
    step();
    step();
    vec++;
    if ({ifu_arvalid, ifu_rready, inst_valid, inst, inst_pc, inst_err, pc} !==
        {3'b000, 32'd0, 64'd0, 1'b0, ResetPc}) begin
      miscmp++;
      $display("FAIL reset: got arv=%b rr=%b iv=%b inst=%h ipc=%h err=%b pc=%h, want zeros pc=%h",
               ifu_arvalid, ifu_rready, inst_valid, inst, inst_pc, inst_err, pc, ResetPc);
    end
    rst = 1'b1;
    step();
    exp_pc = ResetPc;
    vec++;
    if ({ifu_arvalid, ifu_araddr} !== {1'b1, ResetPc}) begin
      miscmp++;
      $display("FAIL reset_req: got arvalid=%b araddr=%h, want 1 %h", ifu_arvalid, ifu_araddr,
               ResetPc);
    end
  endtask

  task automatic test_basic();
    do_fetch(64'h00000013_00100093, 2'b00);
    accept_redirect(64'h0000_0000_8000_0004);
    do_fetch(64'h00000013_00100093, 2'b00);
    accept_redirect(64'h0000_0000_8000_0008);
  endtask

  task automatic test_ar_stall();
    ifu_arready = 1'b0;
    for (int i = 0; i < 5; i++) begin
      step();
      vec++;
      if ({ifu_arvalid, ifu_araddr, ifu_rready, inst_valid} !== {1'b1, exp_pc, 2'b00}) begin
        miscmp++;
        $display("FAIL ar_stall: got arvalid=%b araddr=%h rready=%b iv=%b, want 1 %h 0 0",
                 ifu_arvalid, ifu_araddr, ifu_rready, inst_valid, exp_pc);
      end
    end
    do_fetch(64'h12345678_9abcdef0, 2'b00);
  endtask

  task automatic test_hold_stall();
    logic [31:0] held;
    held = sb[0].inst;
    for (int i = 0; i < 4; i++) begin
      nextpc_valid = (i == 1);
      nextpc       = 64'h0000_0000_9000_0000;
      step();
      vec++;
      if ({inst_valid, inst, pc, ifu_arvalid} !== {1'b1, held, exp_pc, 1'b0}) begin
        miscmp++;
        $display("FAIL hold_stall: got iv=%b inst=%h pc=%h arvalid=%b, want 1 %h %h 0",
                 inst_valid, inst, pc, ifu_arvalid, held, exp_pc);
      end
    end
    nextpc_valid = 1'b0;
    accept_redirect(64'h0000_0000_8000_0010);
  endtask

  task automatic test_bus_error();
    exp_t e;
    do_fetch(64'hcafef00d_0badc0de, 2'b10);
    inst_ready = 1'b1;
    step();
    inst_ready = 1'b0;
    step();
    vec++;
    if ({inst_valid, ifu_arvalid, ifu_rready} !== 3'b000) begin
      miscmp++;
      $display("FAIL exec_idle: got iv=%b arvalid=%b rready=%b, want 0 0 0", inst_valid,
               ifu_arvalid, ifu_rready);
    end
    nextpc_valid = 1'b1;
    nextpc       = 64'h0000_0000_8000_0002;
    e.inst = 32'd0;
    e.pc   = 64'h0000_0000_8000_0002;
    e.err  = 1'b1;
    sb.push_back(e);
    step();
    nextpc_valid = 1'b0;
    exp_pc       = 64'h0000_0000_8000_0002;
    vec++;
    if ({ifu_arvalid, inst_valid, inst_err, pc} !== {1'b0, 1'b1, 1'b1, exp_pc}) begin
      miscmp++;
      $display("FAIL misaligned: got arvalid=%b iv=%b err=%b pc=%h, want 0 1 1 %h",
               ifu_arvalid, inst_valid, inst_err, pc, exp_pc);
    end
    // Misaligned redirect straight out of HOLD, then recover to an aligned target.
    accept_redirect(64'h0000_0000_8000_0007);
    accept_redirect(64'h0000_0000_8000_0020);
  endtask

  task automatic test_back_to_back();
    logic [63:0] tgt;
    for (int i = 0; i < 8; i++) begin
      do_fetch({$urandom, $urandom}, 2'b00);
      tgt = {32'd0, 4'h8, 24'($urandom), 2'b00} ;
      accept_redirect(tgt);
    end
  endtask

  task automatic test_reset_mid();
    ifu_arready = 1'b1;
    step();
    ifu_arready = 1'b0;
    vec++;
    if (ifu_rready !== 1'b1) begin
      miscmp++;
      $display("FAIL mid_wait: got rready=%b, want 1", ifu_rready);
    end
    rst = 1'b0;
    step();
    vec++;
    if ({inst_valid, ifu_arvalid, ifu_rready, pc} !== {3'b000, ResetPc}) begin
      miscmp++;
      $display("FAIL mid_reset: got iv=%b arvalid=%b rready=%b pc=%h, want 0 0 0 %h",
               inst_valid, ifu_arvalid, ifu_rready, pc, ResetPc);
    end
    rst        = 1'b1;
    ifu_rvalid = 1'b1;
    ifu_rdata  = 64'h1111_2222_3333_4444;
    step();
    step();
    ifu_rvalid = 1'b0;
    exp_pc     = ResetPc;
    vec++;
    if ({ifu_arvalid, ifu_araddr, ifu_rready, inst_valid} !== {1'b1, ResetPc, 2'b00}) begin
      miscmp++;
      $display("FAIL stale_rvalid: got arvalid=%b araddr=%h rready=%b iv=%b, want 1 %h 0 0",
               ifu_arvalid, ifu_araddr, ifu_rready, inst_valid, ResetPc);
    end
    do_fetch(64'h00000013_00100093, 2'b00);
    accept_redirect(64'h0000_0000_8000_0004);
  endtask

  initial begin
    vec          = 0;
    miscmp       = 0;
    rst          = 1'b0;
    ifu_arready  = 1'b0;
    ifu_rdata    = 64'd0;
    ifu_rresp    = 2'b00;
    ifu_rvalid   = 1'b0;
    inst_ready   = 1'b0;
    nextpc       = 64'd0;
    nextpc_valid = 1'b0;
    exp_pc       = ResetPc;
    test_reset();
    test_basic();
    test_ar_stall();
    test_hold_stall();
    test_bus_error();
    test_back_to_back();
    test_reset_mid();
    vec++;
    if (sb.size() != 0) begin
      miscmp++;
      $display("FAIL sb_drain: got %0d pending, want 0", sb.size());
    end
    $display("== %0d vectors applied, %0d miscompares ==", vec, miscmp);
    $finish;
  end

endmodule
